// File: rtl/spike_pkg.sv
// Shared types and constants for the spike detector front end.
package spike_pkg;

    localparam int PSI_W = 32;
    localparam logic [PSI_W-1:0] PSI_MAX  = '1;
    localparam logic [PSI_W-1:0] PSI_ZERO = '0;

    typedef enum logic [1:0] {
        CAL,
        ARMED,
        REFRACT
    } spike_state_e;

    // Saturate a wide unsigned quantity into the PSI_W range.
    function automatic logic [PSI_W-1:0] sat_psi(input logic [63:0] v);
        return (|v[63:PSI_W]) ? PSI_MAX : v[PSI_W-1:0];
    endfunction

endpackage

// File: rtl/spike_detector_unit_neo.sv
// NEO energy datapath: 3-tap sample window, registered products (stage 1),
// combinational psi subtract with negative clamp and unsigned saturation (stage 2).
module neo_energy_unit
    import spike_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic                     clk,
    input  logic                     i_rst_n,
    input  logic                     i_valid,
    input  logic signed [DATA_W-1:0] i_sample,
    output logic                     o_valid,
    output logic [PSI_W-1:0]         o_psi
);

    localparam int PROD_W = 2 * DATA_W;
    localparam int DIFF_W = PROD_W + 1;
    localparam int EXT_W  = (DIFF_W > PSI_W + 2) ? DIFF_W : PSI_W + 2;

    logic signed [DATA_W-1:0] r_x1;
    logic signed [DATA_W-1:0] r_x2;
    logic [1:0]               r_fill;
    logic                     r_valid;
    logic signed [PROD_W-1:0] r_prod_cross;
    logic signed [PROD_W-1:0] r_prod_sq;
    logic signed [PROD_W-1:0] w_x0_ext;
    logic signed [PROD_W-1:0] w_x1_ext;
    logic signed [PROD_W-1:0] w_x2_ext;
    logic signed [DIFF_W-1:0] w_diff;
    logic signed [EXT_W-1:0]  w_diff_ext;

    assign w_x0_ext = $signed({{DATA_W{i_sample[DATA_W-1]}}, i_sample});
    assign w_x1_ext = $signed({{DATA_W{r_x1[DATA_W-1]}}, r_x1});
    assign w_x2_ext = $signed({{DATA_W{r_x2[DATA_W-1]}}, r_x2});

    // Products are forced to zero until the window holds three real samples.
    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            r_x1         <= '0;
            r_x2         <= '0;
            r_fill       <= '0;
            r_valid      <= 1'b0;
            r_prod_cross <= '0;
            r_prod_sq    <= '0;
        end else begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_x1 <= i_sample;
                r_x2 <= r_x1;
                if (r_fill != 2'd2) begin
                    r_fill       <= r_fill + 2'd1;
                    r_prod_cross <= '0;
                    r_prod_sq    <= '0;
                end else begin
                    r_prod_cross <= w_x0_ext * w_x2_ext;
                    r_prod_sq    <= w_x1_ext * w_x1_ext;
                end
            end
        end
    end

    assign w_diff     = $signed({r_prod_sq[PROD_W-1], r_prod_sq})
                      - $signed({r_prod_cross[PROD_W-1], r_prod_cross});
    assign w_diff_ext = EXT_W'(w_diff);

    always_comb begin
        o_psi = PSI_ZERO;
        if (w_diff_ext[EXT_W-1]) begin
            o_psi = PSI_ZERO;
        end else if (|w_diff_ext[EXT_W-2:PSI_W]) begin
            o_psi = PSI_MAX;
        end else begin
            o_psi = w_diff_ext[PSI_W-1:0];
        end
    end

    assign o_valid = r_valid;

endmodule

// File: rtl/spike_detector_unit.sv
// Spike detector: NEO energy vs threshold with calibration and refractory FSM.
// Define SPIKE_ADAPTIVE_THRESH_EN for an EMA-based adaptive threshold instead of static_thresh.
module spike_detector_unit
    import spike_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int CAL_SAMPLES = 256,
    parameter int REFRACTORY  = 40,
    parameter int AVG_SHIFT   = 8,
    parameter int THRESH_MULT = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     sample_valid,
    input  logic signed [DATA_W-1:0] sample_in,
    input  logic [31:0]              static_thresh,
    output logic                     current_detection,
    output logic [31:0]              psi_out,
    output logic                     psi_valid,
    output logic                     busy_cal
);

    localparam int CAL_W = $clog2(CAL_SAMPLES + 1);
    localparam int REF_W = (REFRACTORY > 0) ? $clog2(REFRACTORY + 1) : 1;
    localparam logic [CAL_W-1:0] CAL_LAST = CAL_W'(CAL_SAMPLES - 1);
    localparam logic [REF_W-1:0] REF_LOAD = REF_W'(REFRACTORY);
    localparam logic [REF_W-1:0] REF_ONE  = REF_W'(1);

    if (CAL_SAMPLES < 3 || REFRACTORY < 0 || AVG_SHIFT < 0 || AVG_SHIFT > 33 || THRESH_MULT < 1) begin : g_bad_cfg
        $error("spike_detector_unit: illegal parameter combination");
    end

    spike_state_e     r_state;
    spike_state_e     w_next_state;
    logic [CAL_W-1:0] r_cal_cnt;
    logic [REF_W-1:0] r_ref_cnt;
    logic             r_detect;
    logic             r_psi_valid;
    logic [PSI_W-1:0] r_psi;
    logic             w_proc;
    logic [PSI_W-1:0] w_psi;
    logic [PSI_W-1:0] w_thresh;
    logic             w_above;
    logic             w_fire;
    logic             w_busy;

    neo_energy_unit #(
        .DATA_W (DATA_W)
    ) u_neo (
        .clk      (clk),
        .i_rst_n  (reset),
        .i_valid  (sample_valid),
        .i_sample (sample_in),
        .o_valid  (w_proc),
        .o_psi    (w_psi)
    );

`ifdef SPIKE_ADAPTIVE_THRESH_EN
    logic [PSI_W-1:0]  r_mean;
    logic signed [33:0] w_delta;
    logic signed [33:0] w_mean_next;
    logic [63:0]        w_scaled;

    // Mean moves toward psi, so the 34-bit sum always lands back in 0..2^32-1.
    assign w_delta     = ($signed({2'b00, w_psi}) - $signed({2'b00, r_mean})) >>> AVG_SHIFT;
    assign w_mean_next = $signed({2'b00, r_mean}) + w_delta;
    assign w_scaled    = 64'(r_mean) * 64'(THRESH_MULT);
    assign w_thresh    = sat_psi(w_scaled);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_mean <= '0;
        end else if (w_proc) begin
            r_mean <= w_mean_next[PSI_W-1:0];
        end
    end
`else
    assign w_thresh = static_thresh;
`endif

    assign w_above = (w_psi > w_thresh);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= CAL;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            CAL:     if (w_proc && r_cal_cnt == CAL_LAST) w_next_state = ARMED;
            ARMED:   if (w_proc && w_above && REFRACTORY != 0) w_next_state = REFRACT;
            REFRACT: if (w_proc && r_ref_cnt == REF_ONE) w_next_state = ARMED;
            default: w_next_state = CAL;
        endcase
    end

    always_comb begin
        w_fire = 1'b0;
        w_busy = 1'b0;
        if (r_state == ARMED) w_fire = w_proc && w_above;
        if (r_state == CAL)   w_busy = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cal_cnt   <= '0;
            r_ref_cnt   <= '0;
            r_detect    <= 1'b0;
            r_psi_valid <= 1'b0;
            r_psi       <= '0;
        end else begin
            r_detect    <= w_fire;
            r_psi_valid <= w_proc;
            if (w_proc) begin
                r_psi <= w_psi;
                if (r_state == CAL) r_cal_cnt <= r_cal_cnt + CAL_W'(1);
                if (w_fire) begin
                    r_ref_cnt <= REF_LOAD;
                end else if (r_state == REFRACT) begin
                    r_ref_cnt <= r_ref_cnt - REF_ONE;
                end
            end
        end
    end

    assign current_detection = r_detect;
    assign psi_valid         = r_psi_valid;
    assign psi_out           = r_psi;
    assign busy_cal          = w_busy;

endmodule

// File: tb/tb_spike_detector_unit.sv
// Self-checking bench for spike_detector_unit: directed scenarios plus randomized phases
// checked against a sample-history reference model of the NEO detector.
module tb_spike_detector_unit;

    localparam int DATA_W    = 16;
    localparam int CAL       = 4;
    localparam int REF       = 3;
    localparam int AVG_SHIFT = 8;
    localparam int TMULT     = 8;
    localparam longint PMAX  = 64'h0000_0000_FFFF_FFFF;

    logic                     clk = 1'b0;
    logic                     reset = 1'b0;
    logic                     sample_valid = 1'b0;
    logic signed [DATA_W-1:0] sample_in = '0;
    logic [31:0]              static_thresh = 32'd1000;
    logic                     current_detection;
    logic [31:0]              psi_out;
    logic                     psi_valid;
    logic                     busy_cal;

    int tests = 0;
    int fails = 0;

    // Reference model state
    longint hist1, hist2, last_fire, mean, psi_hold, e_psi;
    int     n_acc, n_out;
    bit     e_valid, e_det;

    always #5 clk = ~clk;

    spike_detector_unit #(
        .DATA_W      (DATA_W),
        .CAL_SAMPLES (CAL),
        .REFRACTORY  (REF),
        .AVG_SHIFT   (AVG_SHIFT),
        .THRESH_MULT (TMULT)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .sample_valid      (sample_valid),
        .sample_in         (sample_in),
        .static_thresh     (static_thresh),
        .current_detection (current_detection),
        .psi_out           (psi_out),
        .psi_valid         (psi_valid),
        .busy_cal          (busy_cal)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint thr_now();
`ifdef SPIKE_ADAPTIVE_THRESH_EN
        longint t;
        t = longint'(TMULT) * mean;
        return (t > PMAX) ? PMAX : t;
`else
        return longint'(static_thresh);
`endif
    endfunction

    task automatic model_reset();
        hist1 = 0; hist2 = 0; last_fire = -1; mean = 0; psi_hold = 0;
        n_acc = 0; n_out = 0; e_valid = 0; e_det = 0; e_psi = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0; sample_valid = 1'b0; sample_in = '0;
        @(posedge clk); #1;
        check("rst_det",  64'(current_detection), 64'd0);
        check("rst_pv",   64'(psi_valid),         64'd0);
        check("rst_psi",  64'(psi_out),           64'd0);
        check("rst_busy", 64'(busy_cal),          64'd1);
        @(negedge clk);
        reset = 1'b1;
        model_reset();
    endtask

    // One clock: drive a sample (or bubble), predict its outputs two edges later,
    // and check the outputs belonging to the sample accepted one edge earlier.
    task automatic step(input bit v, input logic signed [DATA_W-1:0] d);
        longint npsi, thr;
        bit     ndet;
        npsi = 0; ndet = 0;
        @(negedge clk);
        sample_valid = v; sample_in = d;
        if (v) begin
            npsi = (n_acc < 2) ? 0 : hist1 * hist1 - longint'(d) * hist2;
            if (npsi < 0) npsi = 0;
            if (npsi > PMAX) npsi = PMAX;
            thr  = thr_now();
            ndet = (n_acc >= CAL) && (last_fire < 0 || n_acc - last_fire > REF) && (npsi > thr);
            if (ndet) last_fire = n_acc;
            mean = mean + ((npsi - mean) >>> AVG_SHIFT);
            hist2 = hist1; hist1 = longint'(d); n_acc++;
        end
        @(posedge clk); #1;
        if (e_valid) begin
            n_out++;
            psi_hold = e_psi;
        end
        check("psi_valid", 64'(psi_valid),         64'(e_valid));
        check("psi_out",   64'(psi_out),           64'(psi_hold));
        check("detect",    64'(current_detection), 64'(e_det));
        check("busy_cal",  64'(busy_cal),          64'(n_out < CAL));
        e_valid = v; e_psi = npsi; e_det = ndet;
    endtask

    task automatic rand_step(input int spike_pct);
        int r;
        logic signed [DATA_W-1:0] d;
        r = int'($urandom_range(0, 99));
        if (r < spike_pct) begin
            d = DATA_W'(int'($urandom_range(100, 32767)));
            if ($urandom_range(0, 1) == 1) d = -d;
        end else if (r == 99) begin
            d = 16'sh8000;
        end else begin
            d = DATA_W'(int'($urandom_range(0, 100)) - 50);
        end
        step($urandom_range(0, 9) < 7, d);
    endtask

    logic signed [DATA_W-1:0] t1 [8] = '{16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd100, 16'sd0, 16'sd0};
    logic [31:0] thr_tab [6] = '{32'd0, 32'd5000, 32'd200000, 32'd1000000, 32'h7FFF_0000, 32'hFFFF_FFFF};

    initial begin
        model_reset();
        repeat (2) @(posedge clk);

        // Single impulse with a fixed threshold, then drain
        static_thresh = 32'd1000;
        do_reset();
        for (int i = 0; i < 8; i++) step(1'b1, t1[i]);
        repeat (3) step(1'b0, '0);

        // Impulse inside calibration must not fire
        do_reset();
        step(1'b1, 16'sd0); step(1'b1, 16'sd100);
        repeat (6) step(1'b1, 16'sd0);

        // Impulses every two samples exercise the refractory window
        do_reset();
        repeat (6) step(1'b1, 16'sd0);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 16'sd100);
            step(1'b1, 16'sd0);
        end
        repeat (3) step(1'b0, '0);

        // Same data with bubbles between samples
        do_reset();
        for (int i = 0; i < 8; i++) begin
            step(1'b1, t1[i]);
            step(1'b0, 16'sd7);
        end

        // Threshold equality boundary: psi == 10000 must not fire, 9999 must
        static_thresh = 32'd10000;
        do_reset();
        for (int i = 0; i < 8; i++) step(1'b1, t1[i]);
        static_thresh = 32'd9999;
        do_reset();
        for (int i = 0; i < 8; i++) step(1'b1, t1[i]);

        // Full-scale samples, threshold 0
        static_thresh = 32'd0;
        do_reset();
        repeat (5) step(1'b1, 16'sd0);
        step(1'b1, 16'sh8000); step(1'b1, 16'sh7FFF); step(1'b1, 16'sh8000);
        step(1'b1, 16'sh8000); step(1'b1, 16'sh7FFF);
        repeat (6) step(1'b1, 16'sd0);

        // Reset while the spike's psi is in flight discards it
        static_thresh = 32'd1000;
        do_reset();
        repeat (6) step(1'b1, 16'sd0);
        step(1'b1, 16'sd100);
        step(1'b1, 16'sd0);
        do_reset();
        repeat (4) step(1'b1, 16'sd0);

        // Randomized phases
        for (int ph = 0; ph < 6; ph++) begin
            static_thresh = thr_tab[ph];
            do_reset();
            for (int i = 0; i < 250; i++) rand_step(10);
        end

`ifdef SPIKE_ADAPTIVE_THRESH_EN
        // Noise builds the mean, then a large spike stands out
        do_reset();
        for (int i = 0; i < 512; i++) step(1'b1, ($urandom_range(0, 1) == 1) ? 16'sd10 : -16'sd10);
        step(1'b1, 16'sd200);
        repeat (4) step(1'b1, 16'sd0);
        for (int i = 0; i < 6; i++) step(1'b1, (i % 2 == 0) ? 16'sd10 : -16'sd10);
        repeat (3) step(1'b0, '0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
